// File: rtl/hopfield_pkg.sv
// Shared types and constants for the hopfield_network phase sequencer.
package hopfield_pkg;

    localparam int unsigned N_NEURONS    = 7;
    localparam int unsigned N_PATTERN_IN = 4;

    localparam logic CMD_TRAIN  = 1'b0;
    localparam logic CMD_RECALL = 1'b1;

    typedef enum logic [2:0] {
        StIdle,
        StDrive,
        StRest,
        StCue,
        StObserve,
        StReport
    } state_e;

endpackage

// File: rtl/hopfield_sequencer_spike_counter_bank.sv
// Bank of N saturating spike counters with synchronous clear and a shared count enable.
// Exposes the post-update count so a decision can be registered in the same edge as the last sample.
module spike_counter_bank #(
    parameter int unsigned N     = 7,
    parameter int unsigned CNT_W = 8
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               clr,
    input  logic               en,
    input  logic [N-1:0]       inc,
    output logic [N*CNT_W-1:0] count_next
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [N*CNT_W-1:0] count_q;

    always_comb begin
        count_next = count_q;
        for (int k = 0; k < N; k++) begin
            if (clr) begin
                count_next[k*CNT_W +: CNT_W] = '0;
            end else if (en && inc[k] && (count_q[k*CNT_W +: CNT_W] != CNT_MAX)) begin
                count_next[k*CNT_W +: CNT_W] = count_q[k*CNT_W +: CNT_W] + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_next;
        end
    end

endmodule

// File: rtl/hopfield_sequencer.sv
// Phase controller for hopfield_network: runs train epochs (drive/rest) and recalls (cue/observe),
// then reports a thresholded per-neuron spike count as the recalled pattern.
module hopfield_sequencer
    import hopfield_pkg::*;
#(
    parameter int unsigned TRAIN_CYCLES = 64,
    parameter int unsigned REST_CYCLES  = 16,
    parameter int unsigned EPOCHS       = 4,
    parameter int unsigned CUE_CYCLES   = 8,
    parameter int unsigned OBS_CYCLES   = 128,
    parameter int unsigned CNT_W        = 8,
    parameter int unsigned SPIKE_THRESH = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_mode,
    input  logic [3:0] cmd_pattern,
    input  logic       abort,
    input  logic [6:0] spikes,
    output logic       learning_enable,
    output logic [3:0] pattern_input,
    output logic [6:0] result_pattern,
    output logic       result_valid,
    output logic       done,
    output logic       busy
);

    localparam int unsigned MAX_TR = (TRAIN_CYCLES > REST_CYCLES) ? TRAIN_CYCLES : REST_CYCLES;
    localparam int unsigned MAX_RC = (CUE_CYCLES > OBS_CYCLES) ? CUE_CYCLES : OBS_CYCLES;
    localparam int unsigned MAX_PH = (MAX_TR > MAX_RC) ? MAX_TR : MAX_RC;
    localparam int unsigned PH_W   = $clog2(MAX_PH + 1);
    localparam int unsigned EP_W   = $clog2(EPOCHS + 1);

    localparam logic [PH_W-1:0]  PH_TRAIN = PH_W'(TRAIN_CYCLES - 1);
    localparam logic [PH_W-1:0]  PH_REST  = PH_W'(REST_CYCLES - 1);
    localparam logic [PH_W-1:0]  PH_CUE   = PH_W'(CUE_CYCLES - 1);
    localparam logic [PH_W-1:0]  PH_OBS   = PH_W'(OBS_CYCLES - 1);
    localparam logic [EP_W-1:0]  EP_LOAD  = EP_W'(EPOCHS);
    localparam logic [EP_W-1:0]  EP_LAST  = EP_W'(1);
    localparam logic [CNT_W:0]   THRESH   = (CNT_W + 1)'(SPIKE_THRESH);

    state_e                    state_q, state_d;
    logic [PH_W-1:0]           phase_q, phase_d;
    logic [EP_W-1:0]           epoch_q, epoch_d;
    logic [3:0]                pat_q, pat_d;
    logic                      le_d, done_d, rv_d, ready_d;
    logic [3:0]                pi_d;
    logic [6:0]                res_d, hit;
    logic                      cnt_clr, cnt_en;
    logic [N_NEURONS*CNT_W-1:0] count_next;

    spike_counter_bank #(
        .N     (N_NEURONS),
        .CNT_W (CNT_W)
    ) u_counters (
        .clk        (clk),
        .reset_n    (reset_n),
        .clr        (cnt_clr),
        .en         (cnt_en),
        .inc        (spikes),
        .count_next (count_next)
    );

    // Threshold on the post-update count so the final OBSERVE sample is included.
    always_comb begin
        hit = '0;
        for (int k = 0; k < N_NEURONS; k++) begin
            hit[k] = {1'b0, count_next[k*CNT_W +: CNT_W]} >= THRESH;
        end
    end

    always_comb begin
        state_d = state_q;
        phase_d = (phase_q != '0) ? phase_q - 1'b1 : '0;
        epoch_d = epoch_q;
        pat_d   = pat_q;
        le_d    = 1'b0;
        pi_d    = '0;
        done_d  = 1'b0;
        rv_d    = 1'b0;
        res_d   = result_pattern;
        cnt_clr = 1'b0;
        cnt_en  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (cmd_valid) begin
                    pat_d = cmd_pattern;
                    le_d  = 1'b1;
                    pi_d  = cmd_pattern;
                    if (cmd_mode == CMD_RECALL) begin
                        state_d = StCue;
                        phase_d = PH_CUE;
                    end else begin
                        state_d = StDrive;
                        phase_d = PH_TRAIN;
                        epoch_d = EP_LOAD;
                    end
                end
            end
            StDrive: begin
                if (phase_q == '0) begin
                    state_d = StRest;
                    phase_d = PH_REST;
                end else begin
                    le_d = 1'b1;
                    pi_d = pat_q;
                end
            end
            StRest: begin
                if (phase_q == '0) begin
                    if (epoch_q == EP_LAST) begin
                        state_d = StReport;
                        epoch_d = '0;
                        done_d  = 1'b1;
                    end else begin
                        state_d = StDrive;
                        epoch_d = epoch_q - 1'b1;
                        phase_d = PH_TRAIN;
                        le_d    = 1'b1;
                        pi_d    = pat_q;
                    end
                end
            end
            StCue: begin
                if (phase_q == '0) begin
                    state_d = StObserve;
                    phase_d = PH_OBS;
                    cnt_clr = 1'b1;
                end else begin
                    le_d = 1'b1;
                    pi_d = pat_q;
                end
            end
            StObserve: begin
                cnt_en = 1'b1;
                if (phase_q == '0) begin
                    state_d = StReport;
                    done_d  = 1'b1;
                    rv_d    = 1'b1;
                    res_d   = hit;
                end
            end
            StReport: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Abort overrides everything decided above, including a phase expiry this cycle.
        if (abort && (state_q != StIdle)) begin
            state_d = StIdle;
            phase_d = '0;
            epoch_d = '0;
            le_d    = 1'b0;
            pi_d    = '0;
            done_d  = 1'b0;
            rv_d    = 1'b0;
            res_d   = result_pattern;
            cnt_clr = 1'b1;
            cnt_en  = 1'b0;
        end

        ready_d = (state_d == StIdle);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q         <= StIdle;
            phase_q         <= '0;
            epoch_q         <= '0;
            pat_q           <= '0;
            learning_enable <= 1'b0;
            pattern_input   <= '0;
            result_pattern  <= '0;
            result_valid    <= 1'b0;
            done            <= 1'b0;
            cmd_ready       <= 1'b1;
            busy            <= 1'b0;
        end else begin
            state_q         <= state_d;
            phase_q         <= phase_d;
            epoch_q         <= epoch_d;
            pat_q           <= pat_d;
            learning_enable <= le_d;
            pattern_input   <= pi_d;
            result_pattern  <= res_d;
            result_valid    <= rv_d;
            done            <= done_d;
            cmd_ready       <= ready_d;
            busy            <= ~ready_d;
        end
    end

endmodule

// File: tb/tb_hopfield_sequencer.sv
// Bench for hopfield_sequencer: default instance plus a CNT_W=4 instance sharing the same stimulus.
module tb_hopfield_sequencer;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_mode = 1'b0;
    logic [3:0] cmd_pattern = '0;
    logic       abort = 1'b0;
    logic [6:0] spikes = '0;

    logic       cmd_ready, learning_enable, result_valid, done, busy;
    logic [3:0] pattern_input;
    logic [6:0] result_pattern;
    logic       d2_ready, d2_le, d2_rv, d2_done, d2_busy;
    logic [3:0] d2_pi;
    logic [6:0] d2_res;

    int         errors = 0;
    int         checks = 0;
    logic [6:0] sb[$];
    logic [6:0] sb4[$];
    logic [6:0] last_res = '0;

    always #5 clk = ~clk;

    hopfield_sequencer dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .cmd_valid       (cmd_valid),
        .cmd_ready       (cmd_ready),
        .cmd_mode        (cmd_mode),
        .cmd_pattern     (cmd_pattern),
        .abort           (abort),
        .spikes          (spikes),
        .learning_enable (learning_enable),
        .pattern_input   (pattern_input),
        .result_pattern  (result_pattern),
        .result_valid    (result_valid),
        .done            (done),
        .busy            (busy)
    );

    hopfield_sequencer #(.CNT_W(4)) dut4 (
        .clk             (clk),
        .reset_n         (reset_n),
        .cmd_valid       (cmd_valid),
        .cmd_ready       (d2_ready),
        .cmd_mode        (cmd_mode),
        .cmd_pattern     (cmd_pattern),
        .abort           (abort),
        .spikes          (spikes),
        .learning_enable (d2_le),
        .pattern_input   (d2_pi),
        .result_pattern  (d2_res),
        .result_valid    (d2_rv),
        .done            (d2_done),
        .busy            (d2_busy)
    );

    // Spike stimulus for recall scenarios, indexed by cycle offset k from the accept cycle.
    function automatic logic [6:0] spike_model(input int scen, input int k);
        logic [6:0] v;
        v = '0;
        if (k <= 8) begin
            v = 7'h7f;
        end else if (k <= 136) begin
            if (scen == 1) begin
                v[0] = 1'b1;
                v[1] = (k <= 11);
                v[6] = (k == 20) || (k == 40) || (k == 60) || (k == 80);
            end else begin
                v[2] = 1'b1;
                v[3] = (k <= 25);
                v[4] = (k <= 11);
            end
        end
        return v;
    endfunction

    task automatic issue(input logic mode, input logic [3:0] pat);
        @(negedge clk);
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL issue_ready: got %b want 1", cmd_ready);
        end
        cmd_valid   = 1'b1;
        cmd_mode    = mode;
        cmd_pattern = pat;
        @(negedge clk);
        cmd_valid   = 1'b0;
        cmd_pattern = '0;
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({learning_enable, pattern_input, result_pattern, result_valid, done, cmd_ready, busy}
            !== 16'b0_0000_0000000_0_0_1_0) begin
            errors++;
            $display("FAIL reset_values: le=%b pi=%h res=%h rv=%b done=%b rdy=%b busy=%b",
                     learning_enable, pattern_input, result_pattern, result_valid, done,
                     cmd_ready, busy);
        end
        reset_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if ({learning_enable, pattern_input, result_valid, done, cmd_ready, busy}
                !== 9'b0_0000_0_0_1_0) begin
                errors++;
                $display("FAIL idle_hold: le=%b pi=%h rv=%b done=%b rdy=%b busy=%b",
                         learning_enable, pattern_input, result_valid, done, cmd_ready, busy);
            end
            checks++;
            if ({d2_le, d2_pi, d2_ready, d2_busy} !== 7'b0_0000_1_0) begin
                errors++;
                $display("FAIL idle_hold_cnt4: le=%b pi=%h rdy=%b busy=%b",
                         d2_le, d2_pi, d2_ready, d2_busy);
            end
        end
    endtask

    task automatic test_train;
        logic       exp_le;
        logic [3:0] exp_pi;
        issue(1'b0, 4'b1010);
        for (int k = 1; k <= 325; k++) begin
            spikes = 7'($urandom);
            exp_le = (k <= 320) && (((k - 1) % 80) < 64);
            exp_pi = exp_le ? 4'b1010 : 4'b0000;
            checks++;
            if ({learning_enable, pattern_input} !== {exp_le, exp_pi}) begin
                errors++;
                $display("FAIL train_drive k=%0d: le=%b pi=%b want le=%b pi=%b",
                         k, learning_enable, pattern_input, exp_le, exp_pi);
            end
            checks++;
            if ({done, cmd_ready, busy} !== {k == 321, k >= 322, k < 322}) begin
                errors++;
                $display("FAIL train_ctrl k=%0d: done=%b rdy=%b busy=%b", k, done, cmd_ready, busy);
            end
            checks++;
            if (result_valid !== 1'b0 || result_pattern !== last_res) begin
                errors++;
                $display("FAIL train_result k=%0d: rv=%b res=%b want rv=0 res=%b",
                         k, result_valid, result_pattern, last_res);
            end
            @(negedge clk);
        end
        spikes = '0;
    endtask

    task automatic recall_run(input logic [3:0] cue, input int scen, input logic [6:0] exp8,
                              input logic [6:0] exp4);
        logic       got, got4;
        logic [6:0] want;
        sb.push_back(exp8);
        sb4.push_back(exp4);
        got  = 1'b0;
        got4 = 1'b0;
        issue(1'b1, cue);
        for (int k = 1; k <= 140; k++) begin
            spikes = spike_model(scen, k);
            checks++;
            if ({learning_enable, pattern_input, d2_le} !==
                {k <= 8, (k <= 8) ? cue : 4'b0000, k <= 8}) begin
                errors++;
                $display("FAIL recall_cue k=%0d: le=%b pi=%b le4=%b", k, learning_enable,
                         pattern_input, d2_le);
            end
            checks++;
            if ({done, d2_done, cmd_ready} !== {k == 137, k == 137, k >= 138}) begin
                errors++;
                $display("FAIL recall_ctrl k=%0d: done=%b done4=%b rdy=%b",
                         k, done, d2_done, cmd_ready);
            end
            if (result_valid) begin
                got = 1'b1;
                want = (sb.size() != 0) ? sb.pop_front() : 7'bx;
                checks++;
                if (k != 137 || result_pattern !== want) begin
                    errors++;
                    $display("FAIL recall_result k=%0d: got %b want %b at k=137",
                             k, result_pattern, want);
                end
                last_res = want;
            end
            if (d2_rv) begin
                got4 = 1'b1;
                want = (sb4.size() != 0) ? sb4.pop_front() : 7'bx;
                checks++;
                if (k != 137 || d2_res !== want) begin
                    errors++;
                    $display("FAIL recall_result_cnt4 k=%0d: got %b want %b at k=137",
                             k, d2_res, want);
                end
            end
            @(negedge clk);
        end
        spikes = '0;
        checks++;
        if (!got || !got4) begin
            errors++;
            $display("FAIL recall_timeout: result_valid seen=%b cnt4=%b want 1 1", got, got4);
        end
        checks++;
        if (result_pattern !== last_res) begin
            errors++;
            $display("FAIL recall_hold: got %b want %b", result_pattern, last_res);
        end
    endtask

    task automatic test_recall;
        recall_run(4'b0101, 1, 7'b1000001, 7'b1000001);
    endtask

    task automatic test_saturation;
        recall_run(4'b1100, 2, 7'b0001100, 7'b0001100);
    endtask

    task automatic test_abort;
        issue(1'b0, 4'b0011);
        for (int k = 1; k <= 100; k++) begin
            checks++;
            if ({learning_enable, done} !== {(k <= 64) || (k >= 81), 1'b0}) begin
                errors++;
                $display("FAIL abort_pre k=%0d: le=%b done=%b", k, learning_enable, done);
            end
            if (k == 100) abort = 1'b1;
            @(negedge clk);
        end
        abort = 1'b0;
        for (int i = 0; i < 10; i++) begin
            checks++;
            if ({learning_enable, pattern_input, done, cmd_ready, busy} !== 8'b0_0000_0_1_0) begin
                errors++;
                $display("FAIL abort_post i=%0d: le=%b pi=%b done=%b rdy=%b busy=%b",
                         i, learning_enable, pattern_input, done, cmd_ready, busy);
            end
            @(negedge clk);
        end
        // Abort coinciding with the last DRIVE cycle must win over the move to REST.
        issue(1'b0, 4'b1001);
        for (int k = 1; k <= 64; k++) begin
            if (k == 64) abort = 1'b1;
            @(negedge clk);
        end
        abort = 1'b0;
        checks++;
        if ({cmd_ready, learning_enable} !== 2'b10) begin
            errors++;
            $display("FAIL abort_priority: rdy=%b le=%b want rdy=1 le=0", cmd_ready, learning_enable);
        end
        abort = 1'b1;
        repeat (3) @(negedge clk);
        abort = 1'b0;
        checks++;
        if ({cmd_ready, learning_enable, done, result_pattern} !== {3'b100, last_res}) begin
            errors++;
            $display("FAIL abort_idle: rdy=%b le=%b done=%b res=%b want res=%b",
                     cmd_ready, learning_enable, done, result_pattern, last_res);
        end
        recall_run(4'b0111, 1, 7'b1000001, 7'b1000001);
    endtask

    task automatic test_busy_reset;
        issue(1'b1, 4'b0110);
        cmd_valid   = 1'b1;
        cmd_mode    = 1'b0;
        cmd_pattern = 4'b1111;
        for (int k = 1; k <= 49; k++) begin
            spikes = 7'($urandom);
            checks++;
            if ({learning_enable, pattern_input, cmd_ready} !==
                {k <= 8, (k <= 8) ? 4'b0110 : 4'b0000, 1'b0}) begin
                errors++;
                $display("FAIL busy_ignore k=%0d: le=%b pi=%b rdy=%b",
                         k, learning_enable, pattern_input, cmd_ready);
            end
            @(negedge clk);
        end
        reset_n = 1'b0;
        #1;
        checks++;
        if ({learning_enable, pattern_input, result_pattern, result_valid, done, cmd_ready, busy}
            !== 16'b0_0000_0000000_0_0_1_0) begin
            errors++;
            $display("FAIL async_reset: le=%b pi=%h res=%b rv=%b done=%b rdy=%b busy=%b",
                     learning_enable, pattern_input, result_pattern, result_valid, done,
                     cmd_ready, busy);
        end
        cmd_valid = 1'b0;
        spikes    = '0;
        repeat (2) @(negedge clk);
        reset_n  = 1'b1;
        last_res = '0;
        repeat (3) @(negedge clk);
        checks++;
        if ({cmd_ready, learning_enable, result_pattern, d2_res} !== {2'b10, 7'b0, 7'b0}) begin
            errors++;
            $display("FAIL post_reset: rdy=%b le=%b res=%b res4=%b",
                     cmd_ready, learning_enable, result_pattern, d2_res);
        end
    endtask

    initial begin
        test_reset();
        test_train();
        test_recall();
        test_saturation();
        test_abort();
        test_busy_reset();
        checks++;
        if (sb.size() != 0 || sb4.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: pending=%0d/%0d want 0/0", sb.size(), sb4.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
